// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM stage of the pipelined RV32 core.
// It accepts one load/store at a time and models a fixed access latency. It steers
// byte, halfword and word lanes and returns a registered response that is held
// until the core takes it.
//
// Ports
//   clk, rst          clock; asynchronous reset, active-low
//   req_valid/ready   request handshake (ready only while IDLE)
//   req_we            1=store, 0=load
//   req_addr          byte address (upper bits beyond the array are ignored)
//   req_funct3        RV32I funct3 of the access
//   req_wdata         right-aligned store data
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load data; 0 for stores and errors
//   rsp_err           misaligned access or illegal funct3
//   busy              high whenever the FSM is not IDLE
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LA_W  = IDX_W + 2;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic               nxt_rsp_valid, nxt_rsp_err;
    logic [31:0]        nxt_rsp_rdata;
    logic               accept_c, commit_c, mem_we_c;

    // Latched request copy; only the bits that select a word and lane are kept.
    logic               lat_we;
    logic [LA_W-1:0]    lat_addr;
    logic [2:0]         lat_f3;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [DEPTH];

    // Address bits above the array index wrap away by design.
    logic               unused_addr_c;
    assign unused_addr_c = ^req_addr[ADDR_W-1:LA_W];

    // Operand source: the live request while IDLE (LATENCY==1 commits on the
    // accept edge), otherwise the latched copy.
    logic               op_we;
    logic [LA_W-1:0]    op_addr;
    logic [2:0]         op_f3;
    logic [31:0]        op_wdata;
    logic [IDX_W-1:0]   op_idx;
    logic [1:0]         op_off;

    always_comb begin
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr[LA_W-1:0];
            op_f3    = req_funct3;
            op_wdata = req_wdata;
        end else begin
            op_we    = lat_we;
            op_addr  = lat_addr;
            op_f3    = lat_f3;
            op_wdata = lat_wdata;
        end
        op_idx = op_addr[LA_W-1:2];
        op_off = op_addr[1:0];
    end

    // Error detection: misalignment, reserved funct3, or an unsigned-style store.
    logic op_err;
    always_comb begin
        op_err = 1'b0;
        if (op_f3[1:0] == 2'b11)                       op_err = 1'b1;
        if (op_f3 == 3'b110)                           op_err = 1'b1;
        if (op_we && op_f3[2])                         op_err = 1'b1;
        if (op_f3[1:0] == 2'b01 && op_off[0])          op_err = 1'b1;
        if (op_f3[1:0] == 2'b10 && op_off != 2'b00)    op_err = 1'b1;
    end

    // Load lane extraction and extension.
    logic [31:0] rd_word, load_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    always_comb begin
        rd_word = mem[op_idx];
        case (op_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = op_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_f3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    // Store byte enables with the data replicated across lanes.
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    always_comb begin
        case (op_f3[1:0])
            2'b00: begin
                st_be = 4'b0001 << op_off;
                st_wd = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                st_be = op_off[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                st_be = 4'b1111;
                st_wd = op_wdata;
            end
            default: begin
                st_be = 4'b0000;
                st_wd = 32'd0;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_rsp_valid = rsp_valid;
        nxt_rsp_rdata = rsp_rdata;
        nxt_rsp_err   = rsp_err;
        accept_c      = 1'b0;
        commit_c      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    nxt_cnt  = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        nxt_state = RESP;
                        commit_c  = 1'b1;
                    end else begin
                        nxt_state = WAIT;
                    end
                end
            end
            WAIT: begin
                nxt_cnt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    nxt_state = RESP;
                    commit_c  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    nxt_state     = IDLE;
                    nxt_rsp_valid = 1'b0;
                end
            end
            default: nxt_state = IDLE;
        endcase
        // Entering RESP: sample load data / error into the held response.
        if (commit_c) begin
            nxt_rsp_valid = 1'b1;
            nxt_rsp_err   = op_err;
            nxt_rsp_rdata = (op_err || op_we) ? 32'd0 : load_data;
        end
    end

    assign mem_we_c = commit_c && op_we && !op_err && rst;

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            req_ready <= (nxt_state == IDLE);
            rsp_valid <= nxt_rsp_valid;
            rsp_rdata <= nxt_rsp_rdata;
            rsp_err   <= nxt_rsp_err;
            busy      <= (nxt_state != IDLE);
            if (accept_c) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr[LA_W-1:0];
                lat_f3    <= req_funct3;
                lat_wdata <= req_wdata;
            end
        end
    end

    // Array write with byte enables; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[op_idx][8*b +: 8] <= st_wd[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 4) share stimulus,
// selected by sel. A transaction-level model predicts outputs every cycle;
// directed transactions also carry hand-computed expected results.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;

    logic        rr2, rv2, re2, bz2, rr4, rv4, re4, bz4;
    logic [31:0] rd2, rd4;

    logic        o_req_ready, o_rsp_valid, o_err, o_busy;
    logic [31:0] o_rdata;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(rr2),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(rd2), .rsp_err(re2), .busy(bz2)
    );

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(rr4),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv4), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(rd4), .rsp_err(re4), .busy(bz4)
    );

    assign o_req_ready = sel ? rr4 : rr2;
    assign o_rsp_valid = sel ? rv4 : rv2;
    assign o_rdata     = sel ? rd4 : rd2;
    assign o_err       = sel ? re4 : re2;
    assign o_busy      = sel ? bz4 : bz2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          lat;
    always_comb lat = sel ? 4 : 2;

    logic [31:0] mm [2][DEPTH];
    bit          m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    int          age = 0;
    bit          q_we;
    logic [31:0] q_addr, q_wd;
    logic [2:0]  q_f3;

    initial begin
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < int'(DEPTH); w++) mm[s][w] = 32'd0;
    end

    // Resolve the pending access: access size 1<<f3[1:0] bytes, natural alignment.
    task automatic resolve();
        int sz, off, w, nb;
        logic [31:0] v, msk;
        bit bad;
        sz  = int'(q_f3[1:0]);
        off = int'(q_addr[1:0]);
        w   = int'((q_addr >> 2) % DEPTH);
        bad = (sz == 3) || (q_f3[2] && (q_we || sz == 2)) ||
              (sz < 3 && (off % (1 << sz)) != 0);
        m_valid = 1'b1;
        m_err   = bad;
        m_rdata = 32'd0;
        if (!bad) begin
            nb = 1 << sz;
            if (q_we) begin
                for (int i = 0; i < nb; i++)
                    mm[sel][w][8*(off+i) +: 8] = q_wd[8*i +: 8];
            end else begin
                v = mm[sel][w] >> (8 * off);
                if (nb < 4) begin
                    msk = (32'd1 << (8 * nb)) - 32'd1;
                    v = v & msk;
                    if (!q_f3[2] && v[8*nb-1]) v = v | ~msk;
                end
                m_rdata = v;
            end
        end
    endtask

    // age = cycles since the accept cycle; the response appears at age == lat.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            age     = 0;
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            age++;
            if (age == lat) resolve();
        end else if (req_valid) begin
            m_busy = 1'b1;
            age    = 1;
            q_we   = req_we;
            q_addr = req_addr;
            q_f3   = req_funct3;
            q_wd   = req_wdata;
            if (age == lat) resolve();
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ctl{ready,valid,busy}", 64'({o_req_ready, o_rsp_valid, o_busy}),
                64'({!m_busy, m_valid, m_busy}));
            if (m_valid) chk("rsp{err,rdata}", 64'({o_err, o_rdata}), 64'({m_err, m_rdata}));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xact(input string nm, input bit we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_d, input bit exp_e, input int hold);
        int n;
        @(negedge clk);
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        n = 1;
        while (!o_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_data"}, 64'({o_err, o_rdata}), 64'({exp_e, exp_d}));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold"}, 64'({o_rsp_valid, o_req_ready, o_busy, o_err, o_rdata}),
                64'({1'b1, 1'b0, 1'b1, exp_e, exp_d}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_rdy_after"}, 64'({o_req_ready, o_rsp_valid}), 64'({1'b1, 1'b0}));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", 64'({o_req_ready, o_rsp_valid, o_busy, o_err, o_rdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
        chk_on = 1'b1;
        rst = 1'b1;

        // Basic word store/load
        xact("sw10",  1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0);
        xact("lw10",  0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, 0);
        // Byte / half lanes and extension
        xact("sb13",  1, 32'h13, 3'b000, 32'h00000080, 32'h0, 0, 0);
        xact("lb13",  0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 0, 0);
        xact("lbu13", 0, 32'h13, 3'b100, 32'h0, 32'h00000080, 0, 0);
        xact("lw10b", 0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0, 0);
        xact("lh12",  0, 32'h12, 3'b001, 32'h0, 32'hFFFF80AD, 0, 0);
        xact("lhu12", 0, 32'h12, 3'b101, 32'h0, 32'h000080AD, 0, 0);
        xact("lb10",  0, 32'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 0, 0);
        xact("lbu11", 0, 32'h11, 3'b100, 32'h0, 32'h000000BE, 0, 0);
        xact("sh10",  1, 32'h10, 3'b001, 32'hABCD1234, 32'h0, 0, 0);
        xact("lh10",  0, 32'h10, 3'b001, 32'h0, 32'h00001234, 0, 0);
        xact("lb11",  0, 32'h11, 3'b000, 32'h0, 32'h00000012, 0, 0);
        // Errors: misalignment and illegal funct3, none may write
        xact("lh11e", 0, 32'h11, 3'b001, 32'h0, 32'h0, 1, 0);
        xact("lw12e", 0, 32'h12, 3'b010, 32'h0, 32'h0, 1, 0);
        xact("sw12e", 1, 32'h12, 3'b010, 32'h55555555, 32'h0, 1, 0);
        xact("sh13e", 1, 32'h13, 3'b001, 32'h55555555, 32'h0, 1, 0);
        xact("f011e", 0, 32'h10, 3'b011, 32'h0, 32'h0, 1, 0);
        xact("f110e", 0, 32'h10, 3'b110, 32'h0, 32'h0, 1, 0);
        xact("f111e", 0, 32'h10, 3'b111, 32'h0, 32'h0, 1, 0);
        xact("s100e", 1, 32'h10, 3'b100, 32'h55555555, 32'h0, 1, 0);
        xact("lw10c", 0, 32'h10, 3'b010, 32'h0, 32'h80AD1234, 0, 0);
        // Response held under back-pressure
        xact("hold",  0, 32'h10, 3'b010, 32'h0, 32'h80AD1234, 0, 5);
        // Address wrap-around modulo 4*DEPTH
        xact("swwrap", 1, 32'h108, 3'b010, 32'h12345678, 32'h0, 0, 0);
        xact("lw08",   0, 32'h8,   3'b010, 32'h0, 32'h12345678, 0, 0);
        xact("lbu10b", 0, 32'h10B, 3'b100, 32'h0, 32'h00000012, 0, 0);

        // LATENCY=4 instance: reset two cycles after accepting a store
        @(negedge clk);
        sel = 1'b1;
        xact("l4_sw20", 1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 0, 0);
        xact("l4_lw20", 0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h11111111;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("l4_busy_pre_rst", 64'({o_busy, o_rsp_valid}), 64'({1'b1, 1'b0}));
        #2 rst = 1'b0;
        #1;
        chk("l4_async_rst", 64'({o_req_ready, o_rsp_valid, o_busy, o_err, o_rdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("l4_no_rsp", 64'({o_rsp_valid, o_busy}), 64'({1'b0, 1'b0}));
        end
        xact("l4_lw20_old", 0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
